// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//
// Front-end controller for a 5-stage MIPS pipeline. Produces the PC write
// enable, the IF/ID stall/flush controls and the ID/EX bubble, resolves
// load-use hazards, taken-branch flushes and the HALT drain sequence, and
// gates the whole pipeline for the debug unit (stop / run / single-step).
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   id_opcode[5:0]  in   opcode held in IF/ID
//   id_rs[4:0]      in   rs field held in IF/ID
//   id_rt[4:0]      in   rt field held in IF/ID
//   id_branch_taken in   branch resolved taken in ID this cycle
//   ex_mem_read     in   instruction in EX is a load
//   ex_rt[4:0]      in   destination rt of the instruction in EX
//   dbg_run         in   pulse: free-run
//   dbg_step        in   pulse: advance one cycle
//   dbg_stop        in   pulse: freeze
//   pipe_en         out  enable for ID/EX, EX/MEM, MEM/WB and RF write
//   pc_write        out  PC load enable
//   if_id_stall     out  hold IF/ID
//   if_id_flush     out  zero IF/ID
//   id_ex_bubble    out  force zero control bits into ID/EX
//   halted          out  pipeline drained and frozen
//   state_o[2:0]    out  current state (STOP=0 RUN=1 STEP=2 DRAIN=3 HALTED=4)
//   cycle_count     out  number of cycles the pipeline advanced (wraps)
//
// Control outputs are combinational from the state register and the current
// inputs; halted and state_o come straight from the state register.

module pipeline_sequencer #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter int         DRAIN_CYCLES = 4,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             dbg_run,
    input  logic             dbg_step,
    input  logic             dbg_stop,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_STOP   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_drain_cnt;
    logic [3:0]       w_next_drain_cnt;
    logic [CNT_W-1:0] r_cycle_count;

    logic w_load_use;
    logic w_halt_id;

    // r0 is never a real producer, so a load to r0 cannot create a hazard.
    assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign w_halt_id  = (id_opcode == HALT_OPCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_STOP;
            r_drain_cnt   <= 4'd0;
            r_cycle_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
            if (pipe_en) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
        end
    end

    always_comb begin
        // Frozen-pipeline values; every state that advances overrides them.
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        pipe_en          = 1'b0;
        pc_write         = 1'b0;
        if_id_stall      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;

        case (r_state)
            S_STOP: begin
                if (dbg_run) begin
                    w_next_state = S_RUN;
                end else if (dbg_step) begin
                    w_next_state = S_STEP;
                end
            end

            S_RUN, S_STEP: begin
                pipe_en = 1'b1;
                // Load-use masks any branch or halt in ID: the stalled
                // instruction is re-examined next cycle.
                if (w_load_use) begin
                    pc_write     = 1'b0;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (w_halt_id) begin
                    pc_write    = 1'b0;
                    if_id_stall = 1'b0;
                    if_id_flush = 1'b1;
                end else if (id_branch_taken) begin
                    pc_write    = 1'b1;
                    if_id_stall = 1'b0;
                    if_id_flush = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_stall = 1'b0;
                end

                // A taken halt beats a simultaneous stop and ends a step.
                if (!w_load_use && w_halt_id) begin
                    w_next_state     = S_DRAIN;
                    w_next_drain_cnt = 4'd0;
                end else if (r_state == S_STEP) begin
                    w_next_state = S_STOP;
                end else if (dbg_stop) begin
                    w_next_state = S_STOP;
                end
            end

            S_DRAIN: begin
                pipe_en          = 1'b1;
                if_id_stall      = 1'b0;
                if_id_flush      = 1'b1;
                id_ex_bubble     = 1'b1;
                w_next_drain_cnt = r_drain_cnt + 4'd1;
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next_state = S_HALTED;
                end
            end

            S_HALTED: begin
                // Only reset leaves this state.
            end

            default: begin
                w_next_state = S_STOP;
            end
        endcase
    end

    assign halted      = (r_state == S_HALTED);
    assign state_o     = r_state;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_branch_taken;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        dbg_run;
  logic        dbg_step;
  logic        dbg_stop;
  logic        pipe_en;
  logic        pc_write;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        halted;
  logic [2:0]  state_o;
  logic [31:0] cycle_count;

  int checks;
  int errors;

  pipeline_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_branch_taken (id_branch_taken),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .dbg_run         (dbg_run),
    .dbg_step        (dbg_step),
    .dbg_stop        (dbg_stop),
    .pipe_en         (pipe_en),
    .pc_write        (pc_write),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .state_o         (state_o),
    .cycle_count     (cycle_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return 1 time unit after it so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    id_opcode       = 6'd0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_branch_taken = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    dbg_run         = 1'b0;
    dbg_step        = 1'b0;
    dbg_stop        = 1'b0;
  endtask

  task automatic check_frozen(input string tag);
    check({tag, "_pipe_en"},  {31'd0, pipe_en},      32'd0);
    check({tag, "_pc_write"}, {31'd0, pc_write},     32'd0);
    check({tag, "_stall"},    {31'd0, if_id_stall},  32'd1);
    check({tag, "_flush"},    {31'd0, if_id_flush},  32'd0);
    check({tag, "_bubble"},   {31'd0, id_ex_bubble}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b0;
    #2;

    // Reset values while reset is held.
    check_frozen("rst");
    check("rst_state",  {29'd0, state_o}, 32'd0);
    check("rst_halted", {31'd0, halted},  32'd0);
    check("rst_count",  cycle_count,      32'd0);

    // 1. Release reset, idle 5 cycles, then run.
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_frozen("idle");
    check("idle_state", {29'd0, state_o}, 32'd0);
    check("idle_count", cycle_count,      32'd0);

    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    settle();
    check("run_state",    {29'd0, state_o},  32'd1);
    check("run_pc_write", {31'd0, pc_write}, 32'd1);
    check("run_pipe_en",  {31'd0, pipe_en},  32'd1);
    check("run_stall",    {31'd0, if_id_stall}, 32'd0);
    check("run_count",    cycle_count,       32'd0);

    // 2. Load-use masks the taken branch.
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_branch_taken = 1'b1;
    settle();
    check("lu_pc_write", {31'd0, pc_write},     32'd0);
    check("lu_stall",    {31'd0, if_id_stall},  32'd1);
    check("lu_bubble",   {31'd0, id_ex_bubble}, 32'd1);
    check("lu_flush",    {31'd0, if_id_flush},  32'd0);
    check("lu_pipe_en",  {31'd0, pipe_en},      32'd1);

    // Load-use through rt as well.
    id_rs = 5'd1; id_rt = 5'd5;
    settle();
    check("lu_rt_bubble", {31'd0, id_ex_bubble}, 32'd1);

    // 3. ex_rt = 0: no hazard, branch flush.
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    settle();
    check("br_flush",    {31'd0, if_id_flush},  32'd1);
    check("br_pc_write", {31'd0, pc_write},     32'd1);
    check("br_stall",    {31'd0, if_id_stall},  32'd0);
    check("br_bubble",   {31'd0, id_ex_bubble}, 32'd0);

    // Stop from RUN; that RUN cycle advanced the pipeline once.
    clear_inputs();
    dbg_stop = 1'b1;
    tick();
    dbg_stop = 1'b0;
    settle();
    check("stop_state", {29'd0, state_o}, 32'd0);
    check("stop_count", cycle_count,      32'd1);
    check_frozen("stop");

    // 4. Three single steps, two idle cycles apart, from a fresh reset.
    do_reset();
    check("s4_count0", cycle_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0;
      settle();
      check("step_state",   {29'd0, state_o},  32'd2);
      check("step_pipe_en", {31'd0, pipe_en},  32'd1);
      check("step_pc_wr",   {31'd0, pc_write}, 32'd1);
      tick();
      check("step_back",    {29'd0, state_o},  32'd0);
      check("step_off",     {31'd0, pipe_en},  32'd0);
      check("step_count",   cycle_count,       32'(k + 1));
      tick();
      check("step_idle",    {31'd0, pipe_en},  32'd0);
      check("step_idle_cnt", cycle_count,      32'(k + 1));
    end

    // Step on a load-use cycle: only the bubble advances, step consumed.
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    settle();
    check("step_lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    check("step_lu_pc",     {31'd0, pc_write},     32'd0);
    tick();
    clear_inputs();
    settle();
    check("step_lu_state", {29'd0, state_o}, 32'd0);
    check("step_lu_count", cycle_count,      32'd4);

    // 5. HALT with simultaneous stop: drain wins.
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    id_opcode = 6'h3F; dbg_stop = 1'b1;
    settle();
    check("halt_pc_write", {31'd0, pc_write},    32'd0);
    check("halt_flush",    {31'd0, if_id_flush}, 32'd1);
    check("halt_pipe_en",  {31'd0, pipe_en},     32'd1);
    tick();
    clear_inputs();
    settle();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) dbg_stop = 1'b1;
      if (i == 2) dbg_run = 1'b1;
      settle();
      check("drain_state",   {29'd0, state_o},     32'd3);
      check("drain_pipe_en", {31'd0, pipe_en},     32'd1);
      check("drain_pc_wr",   {31'd0, pc_write},    32'd0);
      check("drain_flush",   {31'd0, if_id_flush}, 32'd1);
      check("drain_bubble",  {31'd0, id_ex_bubble}, 32'd1);
      check("drain_count",   cycle_count,          32'(5 + i));
      tick();
      clear_inputs();
    end
    settle();
    check("halted_flag",  {31'd0, halted},  32'd1);
    check("halted_state", {29'd0, state_o}, 32'd4);
    check("halted_count", cycle_count,      32'd9);
    check_frozen("halted");
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    tick();
    check("halted_run_state", {29'd0, state_o}, 32'd4);
    check("halted_run_count", cycle_count,      32'd9);

    // 6. Reset in the second DRAIN cycle aborts immediately.
    do_reset();
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    id_opcode = 6'h3F;
    tick();
    clear_inputs();
    tick();
    settle();
    check("d2_state", {29'd0, state_o}, 32'd3);
    reset = 1'b0;
    settle();
    check_frozen("abort");
    check("abort_state",  {29'd0, state_o}, 32'd0);
    check("abort_halted", {31'd0, halted},  32'd0);
    check("abort_count",  cycle_count,      32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_state",  {29'd0, state_o}, 32'd0);
    check("post_halted", {31'd0, halted},  32'd0);
    check("post_count",  cycle_count,      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Controls the front of the 5-stage MIPS pipeline. Generates PC write-enable, IF/ID stall/flush and ID/EX bubble.
- Handles three cases: load-use hazards, taken-branch flushes, and the HALT-opcode drain.
- Gates the whole pipeline for the debug unit (stop/run/single-step).
- Sits between the debug unit, the ID-stage decode outputs and the PC/IF_ID/ID_EX registers.

Parameters:
- HALT_OPCODE, 6'b111111, opcode in ID that starts the drain sequence.
- DRAIN_CYCLES, 4, cycles the back-end keeps running after HALT before freezing (range 1..15).
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_opcode  in  6  opcode held in IF/ID.
- id_rs  in  5  rs field held in IF/ID.
- id_rt  in  5  rt field held in IF/ID.
- id_branch_taken  in  1  branch resolved taken in ID this cycle.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination rt of the instruction in EX.
- dbg_run  in  1  pulse: free-run.
- dbg_step  in  1  pulse: advance one cycle.
- dbg_stop  in  1  pulse: freeze.
- pipe_en  out  1  global enable for the ID/EX, EX/MEM and MEM/WB registers and the register file write.
- pc_write  out  1  PC load enable.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID.
- id_ex_bubble  out  1  force zero control bits into ID/EX.
- halted  out  1  pipeline drained and frozen.
- state_o  out  3  current state, for the debug unit.
- cycle_count  out  CNT_W  count of cycles the pipeline advanced.

Behaviour:
- States and encodings: STOP=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- Reset (reset=0, async):
  - state=STOP, drain_cnt=0, cycle_count=0, halted=0.
  - Outputs while in reset/STOP: pipe_en=0, pc_write=0, if_id_stall=1, if_id_flush=0, id_ex_bubble=0.
  - Reset mid-DRAIN or mid-STEP aborts immediately to these values.
- Derived signals:
  - load_use = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
  - halt_id = (id_opcode==HALT_OPCODE).
- STOP:
  - Frozen outputs as in reset.
  - dbg_run -> RUN. dbg_step -> STEP. dbg_run wins if both are asserted.
- RUN and STEP, pipe_en=1, with hazard priority:
  1. load_use: pc_write=0, if_id_stall=1, if_id_flush=0, id_ex_bubble=1. Any branch or halt in ID is ignored this cycle.
  2. else halt_id: pc_write=0, if_id_flush=1. Next state DRAIN, drain_cnt=0.
  3. else id_branch_taken: pc_write=1, if_id_flush=1.
  4. else: pc_write=1, if_id_stall=0, if_id_flush=0, id_ex_bubble=0.
- RUN transitions:
  - dbg_stop -> STOP, unless halt_id is taken the same cycle; halt wins.
  - dbg_run and dbg_step are ignored.
- STEP:
  - Lasts exactly one cycle, then STOP (or DRAIN if halt_id was taken).
  - A step landing on a load-use cycle still consumes the step: only the bubble advances.
- DRAIN:
  - Outputs: pipe_en=1, pc_write=0, if_id_flush=1, id_ex_bubble=1.
  - drain_cnt increments each cycle. When drain_cnt==DRAIN_CYCLES-1, next state is HALTED.
  - All dbg_* inputs are ignored.
- HALTED:
  - Frozen outputs as in STOP, plus halted=1.
  - Exits only through reset.
- cycle_count:
  - Increments by 1 on each clock edge where pipe_en=1 (RUN, STEP, DRAIN).
  - Wraps from all-ones to 0. Holds otherwise.
- Output timing:
  - All control outputs are combinational from the state register and the current inputs; there is no added latency.
  - halted and state_o come directly from the state register.

Test Plan:
1. Reset release, no dbg input for 5 cycles -> state_o=0, pc_write=0, if_id_stall=1, cycle_count=0. Then pulse dbg_run -> next cycle state_o=1, pc_write=1, pipe_en=1.
2. RUN with ex_mem_read=1, ex_rt=5, id_rs=5, id_branch_taken=1 -> pc_write=0, if_id_stall=1, id_ex_bubble=1, if_id_flush=0.
3. Same as scenario 2 but ex_rt=0 -> no stall; branch flush taken: if_id_flush=1, pc_write=1.
4. From STOP, pulse dbg_step 3 times, 2 idle cycles apart -> pipe_en high for exactly 3 single cycles, cycle_count=3, state_o returns to 0 after each step.
5. RUN with id_opcode=6'h3F and dbg_stop asserted the same cycle -> DRAIN wins. Next DRAIN_CYCLES (4) cycles: pipe_en=1, pc_write=0, if_id_flush=1. Then halted=1, state_o=4, cycle_count frozen; dbg_run has no effect.
6. Assert reset in the 2nd DRAIN cycle -> outputs immediately go to reset values. After release state_o=0, halted=0, cycle_count=0.
